// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter with valid/ready handshakes.
// Defining BIN_TO_BCD_BLANK_EN adds a registered leading-zero blanking output.
`timescale 1ns/1ps
module bin_to_bcd_seq #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5,
   parameter int SIGNED = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    bin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*DIGITS-1:0] bcd,
   output logic                negative,
`ifdef BIN_TO_BCD_BLANK_EN
   output logic [DIGITS-1:0]   blank,
`endif
   output logic                busy
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) begin
         p = p * 64'd10;
      end
      return p;
   endfunction

   localparam logic [63:0] MAX_BIN = (64'd1 << WIDTH) - 64'd1;
   localparam logic [63:0] BCD_SPAN = pow10(DIGITS);

   generate
      if (WIDTH < 4 || WIDTH > 32 || BCD_SPAN <= MAX_BIN) begin : g_param_check
         $error("bin_to_bcd_seq: WIDTH out of range or DIGITS too small to hold 2^WIDTH-1");
      end
   endgenerate

   // Each BCD digit of 5 or more gets +3 so the following left shift carries correctly.
   function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] s);
      logic [BW-1:0] r;
      r = s;
      for (int d = 0; d < DIGITS; d++) begin
         if (s[4*d +: 4] >= 4'd5) begin
            r[4*d +: 4] = s[4*d +: 4] + 4'd3;
         end else begin
            r[4*d +: 4] = s[4*d +: 4];
         end
      end
      return r;
   endfunction

   logic [1:0]       state_r, state_nxt;
   logic [CW-1:0]    cnt_r, cnt_nxt;
   logic [WIDTH-1:0] mag_r, mag_nxt;
   logic [BW-1:0]    scr_r, scr_nxt;
   logic             sign_r, sign_nxt;
   logic [BW-1:0]    bcd_r, bcd_nxt;
   logic             neg_r, neg_nxt;
   logic [BW-1:0]    adj_s;
   logic             bin_neg_s;

   assign bin_neg_s = (SIGNED != 0) && bin[WIDTH-1];

   // Next-state and datapath update for accept, shift and hand-off.
   always_comb begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
      mag_nxt   = mag_r;
      scr_nxt   = scr_r;
      sign_nxt  = sign_r;
      bcd_nxt   = bcd_r;
      neg_nxt   = neg_r;
      adj_s     = dabble_adjust(scr_r);
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               mag_nxt   = bin_neg_s ? (~bin + {{(WIDTH-1){1'b0}}, 1'b1}) : bin;
               sign_nxt  = bin_neg_s;
               scr_nxt   = '0;
               cnt_nxt   = CW'(WIDTH);
               state_nxt = ST_SHIFT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (cnt_r == '0) begin
               bcd_nxt   = scr_r;
               neg_nxt   = sign_r;
               state_nxt = ST_DONE;
            end else begin
               scr_nxt   = {adj_s[BW-2:0], mag_r[WIDTH-1]};
               mag_nxt   = {mag_r[WIDTH-2:0], 1'b0};
               cnt_nxt   = cnt_r - {{(CW-1){1'b0}}, 1'b1};
               state_nxt = ST_SHIFT;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_DONE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         mag_r   <= '0;
         scr_r   <= '0;
         sign_r  <= 1'b0;
         bcd_r   <= '0;
         neg_r   <= 1'b0;
      end else begin
         state_r <= state_nxt;
         cnt_r   <= cnt_nxt;
         mag_r   <= mag_nxt;
         scr_r   <= scr_nxt;
         sign_r  <= sign_nxt;
         bcd_r   <= bcd_nxt;
         neg_r   <= neg_nxt;
      end
   end

`ifdef BIN_TO_BCD_BLANK_EN
   // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
   function automatic logic [DIGITS-1:0] lead_blank(input logic [BW-1:0] s);
      logic [DIGITS-1:0] b;
      logic              zero_above;
      b          = '0;
      zero_above = 1'b1;
      for (int d = DIGITS - 1; d >= 1; d--) begin
         zero_above = zero_above && (s[4*d +: 4] == 4'd0);
         b[d]       = zero_above;
      end
      return b;
   endfunction

   logic [DIGITS-1:0] blank_r;

   // Blank mask is loaded on the same edge as the result digits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_r <= '0;
      end else if (state_r == ST_SHIFT && cnt_r == '0) begin
         blank_r <= lead_blank(scr_r);
      end else begin
         blank_r <= blank_r;
      end
   end

   assign blank = blank_r;
`endif

   assign in_ready  = (state_r == ST_IDLE);
   assign busy      = (state_r == ST_SHIFT);
   assign out_valid = (state_r == ST_DONE);
   assign bcd       = bcd_r;
   assign negative  = neg_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: vector table, random values against a decimal model,
// and hand-written back-pressure and mid-conversion reset sequences.
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;

   logic        clk;
   logic        rst_n;
   logic        iv0, iv1, ordy0, ordy1;
   logic [15:0] b0, b1;
   logic        ir0, ir1, ov0, ov1, neg0, neg1, busy0, busy1;
   logic [19:0] bcd0, bcd1;
`ifdef BIN_TO_BCD_BLANK_EN
   logic [4:0]  blank0, blank1;
`endif

   int errors = 0;
   int checks = 0;

   bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .bin(b0),
      .out_valid(ov0), .out_ready(ordy0), .bcd(bcd0), .negative(neg0),
`ifdef BIN_TO_BCD_BLANK_EN
      .blank(blank0),
`endif
      .busy(busy0)
   );

   bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) dut_u (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .bin(b1),
      .out_valid(ov1), .out_ready(ordy1), .bcd(bcd1), .negative(neg1),
`ifdef BIN_TO_BCD_BLANK_EN
      .blank(blank1),
`endif
      .busy(busy1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Decimal model: magnitude from plain integer arithmetic, digits by repeated division.
   function automatic logic [19:0] ref_bcd(input logic [15:0] v, input bit sgn);
      int unsigned m;
      logic [19:0] r;
      m = (sgn && v >= 16'h8000) ? (32'd65536 - 32'(v)) : 32'(v);
      r = 20'd0;
      for (int d = 0; d < 5; d++) begin
         r[4*d +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic ref_neg(input logic [15:0] v, input bit sgn);
      return sgn && (v >= 16'h8000);
   endfunction

   function automatic logic ov_of(input int u);
      return (u == 0) ? ov0 : ov1;
   endfunction

   function automatic logic ir_of(input int u);
      return (u == 0) ? ir0 : ir1;
   endfunction

   task automatic set_in(input int u, input logic v, input logic [15:0] val);
      if (u == 0) begin iv0 = v; b0 = val; end
      else begin iv1 = v; b1 = val; end
   endtask

   task automatic set_ordy(input int u, input logic v);
      if (u == 0) ordy0 = v;
      else ordy1 = v;
   endtask

   // Issue one request, wait (bounded) for the result, acknowledge it and return to idle.
   task automatic convert(input int u, input logic [15:0] v,
                          output logic [19:0] got, output logic gneg, output int lat);
      check("accept_ready", 32'(ir_of(u)), 32'd1);
      set_in(u, 1'b1, v);
      @(posedge clk); #1;
      set_in(u, 1'b0, 16'h0000);
      check("busy_after_accept", 32'(u == 0 ? busy0 : busy1), 32'd1);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (ov_of(u) !== 1'b1 && lat < 40);
      got  = (u == 0) ? bcd0 : bcd1;
      gneg = (u == 0) ? neg0 : neg1;
      set_ordy(u, 1'b1);
      @(posedge clk); #1;
      set_ordy(u, 1'b0);
      check("idle_after_ack", 32'(ir_of(u)), 32'd1);
   endtask

   typedef struct {
      int          u;
      logic [15:0] bin;
      logic [19:0] exp_bcd;
      logic        exp_neg;
   } vec_t;

   initial begin
      vec_t        vecs[7];
      logic [19:0] got, held;
      logic        gneg;
      int          lat, stray;
      logic [15:0] rv;

      vecs[0] = '{0, 16'h7FFF, 20'h32767, 1'b0};
      vecs[1] = '{0, 16'h8000, 20'h32768, 1'b1};
      vecs[2] = '{0, 16'hFFFF, 20'h00001, 1'b1};
      vecs[3] = '{0, 16'h0000, 20'h00000, 1'b0};
      vecs[4] = '{0, 16'h04D2, 20'h01234, 1'b0};
      vecs[5] = '{1, 16'hFFFF, 20'h65535, 1'b0};
      vecs[6] = '{1, 16'h8000, 20'h32768, 1'b0};

      iv0 = 1'b0; iv1 = 1'b0; b0 = 16'h0000; b1 = 16'h0000;
      ordy0 = 1'b0; ordy1 = 1'b0;
      rst_n = 1'b0;
      #12;
      check("rst_out_valid", 32'(ov0), 32'd0);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_bcd", 32'(bcd0), 32'd0);
      check("rst_negative", 32'(neg0), 32'd0);
`ifdef BIN_TO_BCD_BLANK_EN
      check("rst_blank", 32'(blank0), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_reset", 32'(ir0), 32'd1);

      for (int i = 0; i < 7; i++) begin
         convert(vecs[i].u, vecs[i].bin, got, gneg, lat);
         check($sformatf("vec%0d_bcd", i), 32'(got), 32'(vecs[i].exp_bcd));
         check($sformatf("vec%0d_neg", i), 32'(gneg), 32'(vecs[i].exp_neg));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'd17);
      end

      for (int i = 0; i < 30; i++) begin
         rv = 16'($urandom);
         convert(0, rv, got, gneg, lat);
         check("rand_signed_bcd", 32'(got), 32'(ref_bcd(rv, 1'b1)));
         check("rand_signed_neg", 32'(gneg), 32'(ref_neg(rv, 1'b1)));
      end
      for (int i = 0; i < 10; i++) begin
         rv = 16'($urandom);
         convert(1, rv, got, gneg, lat);
         check("rand_unsigned_bcd", 32'(got), 32'(ref_bcd(rv, 1'b0)));
         check("rand_unsigned_neg", 32'(gneg), 32'd0);
      end

      // Back-pressure: result held while a new request is offered and must be ignored.
      iv0 = 1'b1; b0 = 16'h1234;
      @(posedge clk); #1;
      iv0 = 1'b0;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (ov0 !== 1'b1 && lat < 40);
      check("bp_latency", 32'(lat), 32'd17);
      held = bcd0;
      check("bp_bcd", 32'(held), 32'h04660);
      iv0 = 1'b1; b0 = 16'h0063;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         check("bp_hold_valid", 32'(ov0), 32'd1);
         check("bp_hold_ready", 32'(ir0), 32'd0);
         check("bp_hold_bcd", 32'(bcd0), 32'(held));
      end
      ordy0 = 1'b1;
      @(posedge clk); #1;
      ordy0 = 1'b0; iv0 = 1'b0;
      check("bp_release_ready", 32'(ir0), 32'd1);
      check("bp_release_valid", 32'(ov0), 32'd0);
      @(posedge clk); #1;
      check("bp_idle_holds_bcd", 32'(bcd0), 32'h04660);
      check("bp_not_accepted", 32'(busy0), 32'd0);
      convert(0, 16'h0063, got, gneg, lat);
      check("bp_next_bcd", 32'(got), 32'h00099);

      // Reset in the middle of a conversion aborts it.
      iv0 = 1'b1; b0 = 16'h7FFF;
      @(posedge clk); #1;
      iv0 = 1'b0;
      for (int k = 0; k < 8; k++) begin @(posedge clk); end
      #2;
      check("mid_busy", 32'(busy0), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_valid", 32'(ov0), 32'd0);
      check("abort_busy", 32'(busy0), 32'd0);
      check("abort_bcd", 32'(bcd0), 32'd0);
      check("abort_neg", 32'(neg0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         if (ov0 === 1'b1) stray++;
      end
      check("abort_no_valid", 32'(stray), 32'd0);
      check("abort_ready", 32'(ir0), 32'd1);
      convert(0, 16'h04D2, got, gneg, lat);
      check("after_abort_bcd", 32'(got), 32'h01234);
      check("after_abort_latency", 32'(lat), 32'd17);

`ifdef BIN_TO_BCD_BLANK_EN
      convert(0, 16'h002A, got, gneg, lat);
      check("blank42_bcd", 32'(got), 32'h00042);
      check("blank42_mask", 32'(blank0), 32'b11100);
      convert(0, 16'h0000, got, gneg, lat);
      check("blank0_mask", 32'(blank0), 32'b11110);
      convert(0, 16'h7FFF, got, gneg, lat);
      check("blank_full_mask", 32'(blank0), 32'b00000);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
